trng_sampler: RTL and testbench
===============================

TRNG_SAMPLER -- requirements
Module: trng_sampler

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on rnd_in (minimum 2).
REQ-002 SHALL have parameter SAMPLE_DIV, default 4: the block takes one sample every SAMPLE_DIV clocks (1..255).
REQ-003 SHALL have parameter REP_LIMIT, default 32: count of consecutive identical raw samples that trips the health failure (2..255).
REQ-004 SHALL have port clk, input, 1: the single clock; every flop is rising-edge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port rnd_in, input, 1: free-running ring-oscillator output, asynchronous to clk.
REQ-007 SHALL have port ena, input, 1: sampling enable.
REQ-008 SHALL have port rd_ready, input, 1: consumer accepts byte_out.
REQ-009 SHALL have port byte_out, output, 8: debiased random byte.
REQ-010 SHALL have port byte_valid, output, 1: byte_out holds an unconsumed byte.
REQ-011 SHALL have port overrun, output, 1: sticky; debiased bits were dropped.
REQ-012 SHALL have port health_fail, output, 1: sticky; the repetition-count test tripped.

Function
REQ-013 SHALL pass rnd_in through a chain of SYNC_STAGES flops; all later logic uses only the last stage (s_rnd).
REQ-014 SHALL run a divider counting 0..SAMPLE_DIV-1 while ena=1; a sample strobe fires in each cycle where the count equals SAMPLE_DIV-1, and the count then wraps to 0.
REQ-015 SHALL hold the divider at 0, fire no strobes, and return the pair FSM to EMPTY while ena=0; a partially assembled byte is retained.
REQ-016 SHALL implement a von Neumann pair FSM with states EMPTY and HAVE_FIRST:
- EMPTY + strobe: store s_rnd, go to HAVE_FIRST.
- HAVE_FIRST + strobe, s_rnd differs from the stored bit: emit the stored bit, go to EMPTY.
- HAVE_FIRST + strobe, s_rnd equals the stored bit: emit nothing, go to EMPTY.
REQ-017 SHALL shift each emitted bit into an 8-bit assembly register LSB-first (the first emitted bit lands in bit 0) and increment a 3-bit count.
REQ-018 SHALL transfer the assembly register to byte_out when the 8th bit is captured and the output register is empty or being drained this cycle; byte_valid SHALL be 1 from the next cycle, and the count SHALL wrap to 0.
REQ-019 SHALL, when the 8th bit completes while byte_valid=1 and rd_ready=0, hold the full assembly register, discard later emitted bits, and set overrun; the held byte SHALL transfer in the cycle rd_ready=1 is seen.
REQ-020 SHALL use valid/ready: a transfer occurs when byte_valid=1 and rd_ready=1 in the same cycle; byte_out SHALL be stable while byte_valid=1 and no transfer has occurred.
REQ-021 SHALL, when a transfer and a new-byte load occur in the same cycle, load the new byte and keep byte_valid at 1 with no bubble.
REQ-022 SHALL count consecutive identical raw samples (samples taken on strobes, before debiasing); a differing sample SHALL reset the count to 1.
REQ-023 SHALL set health_fail in the cycle after the REP_LIMIT-th identical sample.
REQ-024 SHALL, once health_fail=1, force byte_valid to 0, stop all assembly and loading, and remain in that state until rst.
REQ-025 SHALL ignore rd_ready while byte_valid=0.

Reset
REQ-026 SHALL, on rst=1 at a rising clk edge, clear the synchronizer, divider, pair FSM (EMPTY), assembly register and count, repetition counter, byte_out (8'h00), byte_valid, overrun and health_fail.
REQ-027 SHALL, on rst asserted mid-byte or with byte_valid=1, discard all data; no output pulse SHALL occur during or after reset.

Verification
REQ-028 SHALL be verified for reset: assert rst for 2 cycles with rnd_in toggling -> byte_out=8'h00 and byte_valid, overrun, health_fail all 0.
REQ-029 SHALL be verified for debiasing and bit order: with SAMPLE_DIV=4, drive sample pairs (0,1) x4 then (1,0) x4, rd_ready=1 -> one byte 8'hF0, byte_valid high for exactly 1 cycle.
REQ-030 SHALL be verified for discarded pairs: pairs (1,1),(0,0) x8 -> byte_valid stays 0 and the count stays 0.
REQ-031 SHALL be verified for the health test: rnd_in held at 1 for 32 strobes -> health_fail=1 one cycle after the 32nd strobe, then byte_valid=0 thereafter regardless of input.
REQ-032 SHALL be verified for backpressure: rd_ready=0 while generating 3 bytes (8'hF0, 8'h0F, 8'hAA) -> byte_out holds 8'hF0, overrun=1; rd_ready=1 for one cycle -> byte_out becomes 8'h0F the next cycle with no byte_valid gap.
REQ-033 SHALL be verified for simultaneous events: rd_ready=1 in the cycle the next byte completes -> byte_valid remains 1 and the new byte appears with no bubble.

Source files
------------

// File: rtl/trng_sampler.sv
// Ring-oscillator sampler: synchronize, decimate, von Neumann debias, pack bytes LSB-first.
// A repetition-count health test latches a permanent failure that blocks all further output.
module trng_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DIV  = 4,
  parameter int REP_LIMIT   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rnd_in,
  input  logic       ena,
  input  logic       rd_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       overrun,
  output logic       health_fail
);

  typedef enum logic {EMPTY = 1'b0, HAVE_FIRST = 1'b1} pair_state_t;

  localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
  localparam logic [7:0] REP_LAST = 8'(REP_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_rnd;
  logic [7:0]             div_q;
  logic                   strobe;
  pair_state_t            state_q, state_d;
  logic                   first_q;
  logic                   emit, emit_bit;
  logic [7:0]             rep_q;
  logic                   last_q;
  logic                   same_sample, rep_hit;
  logic [7:0]             asm_q;
  logic [2:0]             cnt_q;
  logic                   full_q;
  logic                   valid_q;
  logic                   capture, last_bit, drain, load_new, load_held;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rnd_in};
  end
  assign s_rnd = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst || !ena || (div_q == DIV_LAST)) div_q <= 8'd0;
    else                                    div_q <= div_q + 8'd1;
  end
  assign strobe = ena && (div_q == DIV_LAST);

  // Pair FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Pair FSM: next state
  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = EMPTY;
    end else if (strobe) begin
      case (state_q)
        EMPTY:      state_d = HAVE_FIRST;
        HAVE_FIRST: state_d = EMPTY;
        default:    state_d = EMPTY;
      endcase
    end
  end

  // Pair FSM: outputs
  always_comb begin
    emit     = strobe && (state_q == HAVE_FIRST) && (s_rnd != first_q);
    emit_bit = first_q;
  end

  always_ff @(posedge clk) begin
    if (rst)                            first_q <= 1'b0;
    else if (strobe && state_q == EMPTY) first_q <= s_rnd;
  end

  // Repetition count runs on raw strobed samples, before debiasing.
  assign same_sample = (rep_q != 8'd0) && (s_rnd == last_q);
  assign rep_hit     = strobe && same_sample && (rep_q == REP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q       <= 8'd0;
      last_q      <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (strobe) begin
        last_q <= s_rnd;
        if (!same_sample)        rep_q <= 8'd1;
        else if (rep_q != 8'hFF) rep_q <= rep_q + 8'd1;
      end
      if (rep_hit) health_fail <= 1'b1;
    end
  end

  // Handshake: a byte moves when byte_valid and rd_ready are both high in one
  // cycle; byte_out only changes when the register is empty or being drained.
  assign byte_valid = valid_q && !health_fail;
  assign drain      = byte_valid && rd_ready;
  assign capture    = emit && !full_q && !health_fail;
  assign last_bit   = capture && (cnt_q == 3'd7);
  assign load_new   = last_bit && (!byte_valid || drain);
  assign load_held  = full_q && drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q    <= 8'h00;
      cnt_q    <= 3'd0;
      full_q   <= 1'b0;
      overrun  <= 1'b0;
      byte_out <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      if (capture) begin
        asm_q[cnt_q] <= emit_bit;
        cnt_q        <= cnt_q + 3'd1;
      end
      if (last_bit && !load_new) begin
        full_q  <= 1'b1;
        overrun <= 1'b1;
      end
      if (emit && full_q && !health_fail) overrun <= 1'b1;

      if (load_new) begin
        byte_out <= {emit_bit, asm_q[6:0]};
        valid_q  <= 1'b1;
      end else if (load_held) begin
        byte_out <= asm_q;
        full_q   <= 1'b0;
        valid_q  <= 1'b1;
      end else if (drain) begin
        valid_q  <= 1'b0;
      end
      if (health_fail) valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_sampler.sv
// Bench for trng_sampler: directed sample pairs, a byte scoreboard popped by a
// handshake monitor, and direct checks on the sticky flags and stall behaviour.
module tb_trng_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       rnd_in;
  logic       ena;
  logic       rd_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       overrun;
  logic       health_fail;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  trng_sampler #(.SYNC_STAGES(2), .SAMPLE_DIV(4), .REP_LIMIT(32)) dut (
    .clk(clk), .rst(rst), .rnd_in(rnd_in), .ena(ena), .rd_ready(rd_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .overrun(overrun),
    .health_fail(health_fail)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    rnd_in = 1'b0;
    @(posedge clk); #1;
    rnd_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ena = 1'b0;
  endtask

  // Checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted byte is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst === 1'b0 && byte_valid === 1'b1 && rd_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte actual=%02h required=none", byte_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (byte_out !== mon_exp) begin
          failures++;
          $display("FAIL byte_data actual=%02h required=%02h", byte_out, mon_exp);
        end
      end
    end
  end

  // Drivers: each sample window is SAMPLE_DIV cycles aligned to the divider.
  task automatic sample(input logic b, input logic ready_last);
    rnd_in = b;
    repeat (3) @(posedge clk);
    #1;
    if (ready_last) rd_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b, input logic ready_last);
    if (b) begin
      sample(1'b1, 1'b0);
      sample(1'b0, ready_last);
    end else begin
      sample(1'b0, 1'b0);
      sample(1'b1, ready_last);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ready_last);
    for (int i = 0; i < 8; i++) send_bit(b[i], ready_last && (i == 7));
  endtask

  task automatic start_run();
    ena = 1'b1;
  endtask

  task automatic stop_run();
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; ena = 1'b0; rd_ready = 1'b0; rnd_in = 1'b0;
    @(posedge clk); #1;
    do_reset();
    check("reset_byte_out", byte_out, 8'h00);
    check("reset_valid", byte_valid, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_health", health_fail, 1'b0);

    // Debias and bit order: (0,1)x4 then (1,0)x4 -> F0
    rd_ready = 1'b1;
    exp_q.push_back(8'hF0);
    start_run();
    send_byte(8'hF0, 1'b0);
    stop_run();
    check("f0_delivered", exp_q.size(), 0);
    check("f0_single_cycle", byte_valid, 1'b0);

    // Discarded pairs, then a byte proves the bit count stayed at 0
    start_run();
    for (int i = 0; i < 8; i++) begin
      sample(1'b1, 1'b0); sample(1'b1, 1'b0);
      sample(1'b0, 1'b0); sample(1'b0, 1'b0);
    end
    check("discard_no_valid", byte_valid, 1'b0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b0);
    stop_run();
    check("after_discard_delivered", exp_q.size(), 0);

    // Backpressure: three bytes with rd_ready low
    rd_ready = 1'b0;
    start_run();
    send_byte(8'hF0, 1'b0);
    send_byte(8'h0F, 1'b0);
    send_byte(8'hAA, 1'b0);
    stop_run();
    check("bp_hold_byte", byte_out, 8'hF0);
    check("bp_hold_valid", byte_valid, 1'b1);
    check("bp_overrun", overrun, 1'b1);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    check("bp_no_gap_valid", byte_valid, 1'b1);
    check("bp_next_byte", byte_out, 8'h0F);
    rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("bp_drained_valid", byte_valid, 1'b0);
    check("bp_drained_queue", exp_q.size(), 0);
    check("bp_overrun_sticky", overrun, 1'b1);

    // Drain and load in the same cycle
    rd_ready = 1'b0;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    start_run();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b1);
    check("simul_valid", byte_valid, 1'b1);
    check("simul_byte", byte_out, 8'hC3);
    stop_run();
    check("simul_drained_queue", exp_q.size(), 0);
    check("simul_drained_valid", byte_valid, 1'b0);

    // Reset mid-byte discards the partial byte
    rd_ready = 1'b1;
    start_run();
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    do_reset();
    check("midreset_valid", byte_valid, 1'b0);
    check("midreset_overrun", overrun, 1'b0);
    exp_q.push_back(8'h96);
    start_run();
    send_byte(8'h96, 1'b0);
    stop_run();
    check("midreset_fresh_byte", exp_q.size(), 0);

    // Health test: 32 identical samples
    do_reset();
    rd_ready = 1'b1;
    start_run();
    for (int i = 0; i < 31; i++) sample(1'b1, 1'b0);
    check("health_after_31", health_fail, 1'b0);
    rnd_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("health_in_32nd_strobe", health_fail, 1'b0);
    @(posedge clk); #1;
    check("health_tripped", health_fail, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'hA3, 1'b0);
    stop_run();
    check("health_valid_low", byte_valid, 1'b0);
    check("health_sticky", health_fail, 1'b1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
